// File: rtl/neighbourhood_reader.sv
// neighbourhood_reader
//
// Reads the 3x3 Moore neighbourhood around one arena cell through the arena's
// synchronous read port B. It issues three row reads (up, mid, down) and
// returns the centre cell state and the number of live neighbours.
//
// Ports:
//   clk              - single clock, rising edge
//   reset            - synchronous, active-high
//   start            - request strobe, accepted only while ready=1
//   ready            - idle; results reflect the last completed request
//   cell_column      - requested column, sampled on the accepting edge
//   cell_row         - requested row, sampled on the accepting edge
//   cell_value       - centre cell state
//   neighbour_count  - live neighbours, 0..8
//   out_of_range     - last request addressed a cell outside the arena
//   arena_row_select - registered row address to the arena port B
//   arena_columns    - row data for the row addressed at the previous edge
//
// Edge handling: TOROIDAL=1 wraps rows and columns; TOROIDAL=0 treats
// off-arena neighbours as dead but still issues the wrapped row address.

module neighbourhood_reader #(
    parameter int ARENA_WIDTH  = 10,
    parameter int ARENA_HEIGHT = 10,
    parameter int TOROIDAL     = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   ready,
    input  logic [9:0]             cell_column,
    input  logic [9:0]             cell_row,
    output logic                   cell_value,
    output logic [3:0]             neighbour_count,
    output logic                   out_of_range,
    output logic [9:0]             arena_row_select,
    input  logic [ARENA_WIDTH-1:0] arena_columns
);

    localparam logic [9:0] LAST_COL = 10'(ARENA_WIDTH - 1);
    localparam logic [9:0] LAST_ROW = 10'(ARENA_HEIGHT - 1);
    localparam logic       WRAP     = (TOROIDAL != 0);

    typedef enum logic [2:0] {IDLE, ADDR, CAP_UP, CAP_MID, CAP_DOWN} state_t;
    state_t state_reg, state_next;

    // Request decode, straight from the inputs; used only on the accepting edge.
    logic       req_oor;
    logic [9:0] req_up_row, req_down_row, req_left_col, req_right_col;
    logic       req_up_ok, req_down_ok, req_left_ok, req_right_ok;

    assign req_oor       = (cell_column > LAST_COL) || (cell_row > LAST_ROW);
    assign req_up_row    = (cell_row == 10'd0)     ? LAST_ROW : cell_row - 10'd1;
    assign req_down_row  = (cell_row == LAST_ROW)  ? 10'd0    : cell_row + 10'd1;
    assign req_left_col  = (cell_column == 10'd0)  ? LAST_COL : cell_column - 10'd1;
    assign req_right_col = (cell_column == LAST_COL) ? 10'd0  : cell_column + 10'd1;
    assign req_up_ok     = WRAP || (cell_row != 10'd0);
    assign req_down_ok   = WRAP || (cell_row != LAST_ROW);
    assign req_left_ok   = WRAP || (cell_column != 10'd0);
    assign req_right_ok  = WRAP || (cell_column != LAST_COL);

    // Latched request. Taps are ordered left/centre/right, rows up/mid/down.
    // An out-of-range request clears every ok flag so all results read as 0.
    logic       oor_reg;
    logic [9:0] mid_row_reg, down_row_reg;
    logic [9:0] tap_col_reg [3];
    logic [2:0] tap_ok_reg;
    logic [2:0] row_ok_reg;
    logic [2:0] up_bits_reg, mid_bits_reg;

    // Extract the three tap bits of whichever row the arena is presenting.
    logic [2:0] tap_bits;
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_tap
            logic [ARENA_WIDTH-1:0] tap_mask;
            assign tap_mask     = {{(ARENA_WIDTH-1){1'b0}}, 1'b1} << tap_col_reg[gi];
            assign tap_bits[gi] = tap_ok_reg[gi] & (|(arena_columns & tap_mask));
        end
    endgenerate

    logic [2:0] down_bits;
    logic [3:0] count_sum;
    assign down_bits = tap_bits & {3{row_ok_reg[2]}};
    // Centre bit mid_bits_reg[1] is the cell itself and is not a neighbour.
    assign count_sum = 4'(up_bits_reg[0]) + 4'(up_bits_reg[1]) + 4'(up_bits_reg[2])
                     + 4'(mid_bits_reg[0]) + 4'(mid_bits_reg[2])
                     + 4'(down_bits[0]) + 4'(down_bits[1]) + 4'(down_bits[2]);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (start) state_next = ADDR;
            ADDR:     state_next = CAP_UP;
            CAP_UP:   state_next = CAP_MID;
            CAP_MID:  state_next = CAP_DOWN;
            CAP_DOWN: state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            ready            <= 1'b1;
            cell_value       <= 1'b0;
            neighbour_count  <= 4'd0;
            out_of_range     <= 1'b0;
            arena_row_select <= 10'd0;
            oor_reg          <= 1'b0;
            mid_row_reg      <= 10'd0;
            down_row_reg     <= 10'd0;
            tap_col_reg[0]   <= 10'd0;
            tap_col_reg[1]   <= 10'd0;
            tap_col_reg[2]   <= 10'd0;
            tap_ok_reg       <= 3'd0;
            row_ok_reg       <= 3'd0;
            up_bits_reg      <= 3'd0;
            mid_bits_reg     <= 3'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        ready   <= 1'b0;
                        oor_reg <= req_oor;
                        if (req_oor) begin
                            arena_row_select <= 10'd0;
                            mid_row_reg      <= 10'd0;
                            down_row_reg     <= 10'd0;
                            tap_col_reg[0]   <= 10'd0;
                            tap_col_reg[1]   <= 10'd0;
                            tap_col_reg[2]   <= 10'd0;
                            tap_ok_reg       <= 3'd0;
                            row_ok_reg       <= 3'd0;
                        end else begin
                            arena_row_select <= req_up_row;
                            mid_row_reg      <= cell_row;
                            down_row_reg     <= req_down_row;
                            tap_col_reg[0]   <= req_left_col;
                            tap_col_reg[1]   <= cell_column;
                            tap_col_reg[2]   <= req_right_col;
                            tap_ok_reg       <= {req_right_ok, 1'b1, req_left_ok};
                            row_ok_reg       <= {req_down_ok, 1'b1, req_up_ok};
                        end
                    end
                end
                ADDR: arena_row_select <= mid_row_reg;
                CAP_UP: begin
                    up_bits_reg      <= tap_bits & {3{row_ok_reg[0]}};
                    arena_row_select <= down_row_reg;
                end
                CAP_MID: mid_bits_reg <= tap_bits & {3{row_ok_reg[1]}};
                CAP_DOWN: begin
                    cell_value      <= mid_bits_reg[1];
                    neighbour_count <= count_sum;
                    out_of_range    <= oor_reg;
                    ready           <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
